maze_renderer: RTL and testbench

- Parametrised successor to the fixed-layout maze ROMs driving the 96x64 RGB565 OLED.
- Maze geometry (cell grid, pitch, wall thickness) is set by parameters; the wall layout is a runtime input bus, so one block serves every level.
- Adds a player-position FSM with move handshake, wall-collision check, goal/win detection and a 2-stage pixel pipeline.
- Sits between the OLED driver (pixel index in, colour out) and the button/debounce logic (move requests).

---
 rtl/maze_renderer.sv | 218 +++++++++++++++++++++
 tb/tb_maze_renderer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_renderer.sv
// maze_renderer: parametrised maze pixel renderer for a 96x64 RGB565 OLED,
// with a player move FSM, wall collision check and goal detection.
module maze_renderer #(
  parameter int          WIDTH     = 96,
  parameter int          HEIGHT    = 64,
  parameter int          COLS      = 7,
  parameter int          ROWS      = 4,
  parameter int          PITCH_X   = 13,
  parameter int          PITCH_Y   = 15,
  parameter int          WALL      = 3,
  parameter int          START_COL = 0,
  parameter int          START_ROW = 0,
  parameter int          GOAL_COL  = 6,
  parameter int          GOAL_ROW  = 3,
  parameter logic [15:0] WALL_C    = 16'hFFFF,
  parameter logic [15:0] BG_C      = 16'h0000,
  parameter logic [15:0] PLAYER_C  = 16'h001F,
  parameter logic [15:0] GOAL_C    = 16'h07E0,
  parameter int          IDX_W     = 13
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [IDX_W-1:0]         index,
  input  logic                     index_valid,
  output logic [15:0]              data,
  output logic                     data_valid,
  input  logic [(ROWS+1)*COLS-1:0] hwall,
  input  logic [ROWS*(COLS+1)-1:0] vwall,
  input  logic                     move_req,
  input  logic [1:0]               move_dir,
  output logic                     move_ready,
  output logic                     move_done,
  output logic                     move_blocked,
  input  logic                     restart,
  output logic [2:0]               player_col,
  output logic [2:0]               player_row,
  output logic                     won
);

  localparam int XW   = $clog2(WIDTH);
  localparam int YW   = $clog2(HEIGHT);
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int GW   = COLS * PITCH_X + WALL;
  localparam int GH   = ROWS * PITCH_Y + WALL;
  localparam int HN   = (ROWS + 1) * COLS;
  localparam int VN   = ROWS * (COLS + 1);
  localparam int HIW  = $clog2(HN);
  localparam int VIW  = $clog2(VN);

  // ---------------- stage 1 ----------------
  logic [XW-1:0] s1_x;
  logic [YW-1:0] s1_y;
  logic          s1_oob;
  logic          s1_v;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_x   <= '0;
      s1_y   <= '0;
      s1_oob <= 1'b0;
    end else begin
      s1_v   <= index_valid;
      s1_x   <= XW'(32'(index) % WIDTH);
      s1_y   <= YW'(32'(index) / WIDTH);
      s1_oob <= 32'(index) >= NPIX;
    end
  end

  // ---------------- stage 2 ----------------
  int unsigned    xi, yi, pc_i, pr_i;
  int unsigned    cc, xo, rr, yo;
  logic [HIW-1:0] pix_hidx;
  logic [VIW-1:0] pix_vidx;
  logic [15:0]    pix;

  always_comb begin
    xi       = 32'(s1_x);
    yi       = 32'(s1_y);
    pc_i     = 32'(player_col);
    pr_i     = 32'(player_row);
    cc       = xi / PITCH_X;
    xo       = xi % PITCH_X;
    rr       = yi / PITCH_Y;
    yo       = yi % PITCH_Y;
    pix_hidx = HIW'(rr * COLS + cc);
    pix_vidx = VIW'(rr * (COLS + 1) + cc);
    pix      = BG_C;
    // On the last wall line/column only the wall rules can match
    if (s1_oob || xi >= GW || yi >= GH)
      pix = WALL_C;
    else if (xo < WALL && yo < WALL)
      pix = WALL_C;
    else if (xo < WALL)
      pix = vwall[pix_vidx] ? WALL_C : BG_C;
    else if (yo < WALL)
      pix = hwall[pix_hidx] ? WALL_C : BG_C;
    else if (cc == pc_i && rr == pr_i)
      pix = PLAYER_C;
    else if (cc == GOAL_COL && rr == GOAL_ROW)
      pix = GOAL_C;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data       <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= s1_v;
      if (s1_v)
        data <= pix;
    end
  end

  // ---------------- move FSM ----------------
  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    COMMIT
  } state_t;

  state_t         st;
  logic [1:0]     dir_q;
  logic           blk_q;
  logic [2:0]     tcol;
  logic [2:0]     trow;
  logic           chk_blk;
  logic           chk_edge;
  logic           chk_wall;
  logic [2:0]     chk_col;
  logic [2:0]     chk_row;
  logic [HIW-1:0] mv_hidx;
  logic [VIW-1:0] mv_vidx;

  always_comb begin
    chk_col  = player_col;
    chk_row  = player_row;
    chk_edge = 1'b0;
    mv_hidx  = '0;
    mv_vidx  = '0;
    chk_wall = 1'b0;
    unique case (dir_q)
      2'd0: begin
        chk_edge = pr_i == 0;
        mv_hidx  = HIW'(pr_i * COLS + pc_i);
        chk_wall = hwall[mv_hidx];
        chk_row  = player_row - 3'd1;
      end
      2'd1: begin
        chk_edge = pr_i == ROWS - 1;
        mv_hidx  = HIW'((pr_i + 1) * COLS + pc_i);
        chk_wall = hwall[mv_hidx];
        chk_row  = player_row + 3'd1;
      end
      2'd2: begin
        chk_edge = pc_i == 0;
        mv_vidx  = VIW'(pr_i * (COLS + 1) + pc_i);
        chk_wall = vwall[mv_vidx];
        chk_col  = player_col - 3'd1;
      end
      default: begin
        chk_edge = pc_i == COLS - 1;
        mv_vidx  = VIW'(pr_i * (COLS + 1) + pc_i + 1);
        chk_wall = vwall[mv_vidx];
        chk_col  = player_col + 3'd1;
      end
    endcase
    chk_blk = won | chk_edge | chk_wall;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      st           <= IDLE;
      dir_q        <= 2'd0;
      blk_q        <= 1'b0;
      tcol         <= 3'(START_COL);
      trow         <= 3'(START_ROW);
      move_ready   <= 1'b1;
      move_done    <= 1'b0;
      move_blocked <= 1'b0;
      player_col   <= 3'(START_COL);
      player_row   <= 3'(START_ROW);
      won          <= 1'b0;
    end else begin
      move_done    <= 1'b0;
      move_blocked <= 1'b0;
      unique case (st)
        IDLE: begin
          if (move_req) begin
            dir_q      <= move_dir;
            move_ready <= 1'b0;
            st         <= CHECK;
          end
        end
        CHECK: begin
          blk_q <= chk_blk;
          tcol  <= chk_col;
          trow  <= chk_row;
          st    <= COMMIT;
        end
        COMMIT: begin
          if (!blk_q) begin
            player_col <= tcol;
            player_row <= trow;
            if (tcol == 3'(GOAL_COL) && trow == 3'(GOAL_ROW))
              won <= 1'b1;
          end
          move_done    <= 1'b1;
          move_blocked <= blk_q;
          move_ready   <= 1'b1;
          st           <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_renderer.sv
// tb_maze_renderer: scoreboard bench for maze_renderer with a
// geometric reference model of the maze and the player.
module tb_maze_renderer;

  localparam int W    = 96;
  localparam int H    = 64;
  localparam int COLS = 7;
  localparam int ROWS = 4;
  localparam int PX   = 13;
  localparam int PY   = 15;
  localparam int WL   = 3;
  localparam int HWN  = (ROWS + 1) * COLS;
  localparam int VWN  = ROWS * (COLS + 1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [12:0]    index = '0;
  logic           index_valid = 1'b0;
  logic [15:0]    data;
  logic           data_valid;
  logic [HWN-1:0] hwall = '0;
  logic [VWN-1:0] vwall = '0;
  logic           move_req = 1'b0;
  logic [1:0]     move_dir = 2'd0;
  logic           move_ready;
  logic           move_done;
  logic           move_blocked;
  logic           restart = 1'b0;
  logic [2:0]     player_col;
  logic [2:0]     player_row;
  logic           won;

  maze_renderer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .index        (index),
    .index_valid  (index_valid),
    .data         (data),
    .data_valid   (data_valid),
    .hwall        (hwall),
    .vwall        (vwall),
    .move_req     (move_req),
    .move_dir     (move_dir),
    .move_ready   (move_ready),
    .move_done    (move_done),
    .move_blocked (move_blocked),
    .restart      (restart),
    .player_col   (player_col),
    .player_row   (player_row),
    .won          (won)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          cyc;
    logic [15:0] col;
  } pix_t;

  typedef struct {
    int   cyc;
    logic blk;
    int   col;
    int   row;
    logic won;
  } mv_t;

  pix_t pq[$];
  mv_t  mq[$];

  int          m_col = 0;
  int          m_row = 0;
  logic        m_won = 1'b0;
  logic [15:0] last_exp = '0;
  int          ffff_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Geometric model: wall lines are bands [k*P, k*P+WL)
  function automatic logic [15:0] ref_pix(input int idx, input logic [HWN-1:0] hw,
                                          input logic [VWN-1:0] vw,
                                          input int pc, input int pr);
    int x, y, vl, hl, cx, cy;
    logic [HWN-1:0] th;
    logic [VWN-1:0] tv;
    x  = idx % W;
    y  = idx / W;
    vl = -1;
    hl = -1;
    cx = 0;
    cy = 0;
    if (idx >= W * H || x >= COLS * PX + WL || y >= ROWS * PY + WL)
      return 16'hFFFF;
    for (int k = 0; k <= COLS; k++) begin
      if (x >= k * PX && x < k * PX + WL) vl = k;
      if (x >= k * PX) cx = k;
    end
    for (int k = 0; k <= ROWS; k++) begin
      if (y >= k * PY && y < k * PY + WL) hl = k;
      if (y >= k * PY) cy = k;
    end
    if (vl >= 0 && hl >= 0) return 16'hFFFF;
    if (vl >= 0) begin
      tv = vw >> (cy * (COLS + 1) + vl);
      return tv[0] ? 16'hFFFF : 16'h0000;
    end
    if (hl >= 0) begin
      th = hw >> (hl * COLS + cx);
      return th[0] ? 16'hFFFF : 16'h0000;
    end
    if (cx == pc && cy == pr) return 16'h001F;
    if (cx == 6 && cy == 3) return 16'h07E0;
    return 16'h0000;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid) begin
        if (pq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL pix_unexpected: got data %0h expected no pixel", data);
        end else begin
          pix_t p;
          p = pq.pop_front();
          chk("pix_latency", cyc, p.cyc);
          chk("pix_data", data, p.col);
          last_exp = p.col;
          if (data == 16'hFFFF) ffff_seen++;
        end
      end
      if (move_done) begin
        if (mq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL move_unexpected: got move_done 1 expected 0");
        end else begin
          mv_t e;
          e = mq.pop_front();
          chk("move_latency", cyc, e.cyc);
          chk("move_blocked", move_blocked, e.blk);
          chk("move_col", player_col, e.col);
          chk("move_row", player_row, e.row);
          chk("move_won", won, e.won);
        end
      end
    end
  end

  task automatic wait_ready();
    int k;
    k = 0;
    while (move_ready !== 1'b1 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 20) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: got move_ready 0 expected 1");
    end
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while ((pq.size() != 0 || mq.size() != 0) && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= budget) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               pq.size() + mq.size());
      pq.delete();
      mq.delete();
    end
  endtask

  task automatic send_pix(input int idx, input int exp = -1);
    pix_t p;
    index       = 13'(idx);
    index_valid = 1'b1;
    p.cyc = cyc + 2;
    p.col = (exp < 0) ? ref_pix(idx, hwall, vwall, m_col, m_row) : 16'(exp);
    pq.push_back(p);
    @(posedge clk);
    #1;
  endtask

  task automatic do_move(input int dir, input int pulses = 1);
    mv_t e;
    int nc, nr;
    logic blk;
    logic [HWN-1:0] th;
    logic [VWN-1:0] tv;
    wait_ready();
    nc = m_col;
    nr = m_row;
    case (dir)
      0:       nr = nr - 1;
      1:       nr = nr + 1;
      2:       nc = nc - 1;
      default: nc = nc + 1;
    endcase
    blk = m_won || nc < 0 || nc >= COLS || nr < 0 || nr >= ROWS;
    if (!blk) begin
      if (dir < 2) begin
        th  = hwall >> ((nr > m_row ? nr : m_row) * COLS + m_col);
        blk = th[0];
      end else begin
        tv  = vwall >> (m_row * (COLS + 1) + (nc > m_col ? nc : m_col));
        blk = tv[0];
      end
    end
    if (!blk) begin
      m_col = nc;
      m_row = nr;
      if (nc == 6 && nr == 3) m_won = 1'b1;
    end
    e.cyc = cyc + 3;
    e.blk = blk;
    e.col = m_col;
    e.row = m_row;
    e.won = m_won;
    mq.push_back(e);
    move_dir = 2'(dir);
    for (int i = 0; i < pulses; i++) begin
      move_req = 1'b1;
      @(posedge clk);
      #1;
    end
    move_req = 1'b0;
    wait_drain(20);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_restart(input logic with_req);
    restart  = 1'b1;
    move_req = with_req;
    move_dir = 2'd3;
    @(posedge clk);
    #1;
    restart  = 1'b0;
    move_req = 1'b0;
    m_col = 0;
    m_row = 0;
    m_won = 1'b0;
    chk("restart_ready", move_ready, 1);
    chk("restart_col", player_col, 0);
    chk("restart_row", player_row, 0);
    chk("restart_won", won, 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int ffff_exp;
    int x, y, e;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", data, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_ready", move_ready, 1);
    chk("rst_done", move_done, 0);
    chk("rst_blocked", move_blocked, 0);
    chk("rst_col", player_col, 0);
    chk("rst_row", player_row, 0);
    chk("rst_won", won, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // corner post, player sprite, right border
    send_pix(0, 16'hFFFF);
    send_pix(485, 16'h001F);
    send_pix(94, 16'hFFFF);
    index_valid = 1'b0;
    wait_drain(20);
    repeat (3) @(posedge clk);
    #1;
    chk("data_hold", data, last_exp);
    chk("idle_valid", data_valid, 0);

    // wall blocks a right move, then the cleared wall lets it pass
    vwall = VWN'(2);
    do_move(3);
    vwall = '0;
    do_move(3);
    do_restart(1'b0);

    // grid edge, then a triple pulse gives one move
    do_move(0);
    do_move(3, 3);
    do_restart(1'b0);

    // walk to the goal
    send_pix(4883, 16'h07E0);
    index_valid = 1'b0;
    wait_drain(20);
    for (int i = 0; i < 6; i++) do_move(3);
    for (int i = 0; i < 3; i++) do_move(1);
    chk("goal_won", won, 1);
    do_move(2);
    send_pix(4883, 16'h001F);
    index_valid = 1'b0;
    wait_drain(20);

    // restart with a request, and restart mid-CHECK
    do_restart(1'b1);
    wait_ready();
    move_dir = 2'd3;
    move_req = 1'b1;
    @(posedge clk);
    #1;
    move_req = 1'b0;
    do_restart(1'b0);

    // reset mid-move drops the move
    wait_ready();
    move_req = 1'b1;
    @(posedge clk);
    #1;
    move_req = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_col = 0;
    m_row = 0;
    m_won = 1'b0;
    chk("midrst_ready", move_ready, 1);
    chk("midrst_data", data, 0);
    chk("midrst_col", player_col, 0);
    repeat (4) @(posedge clk);
    #1;

    // full frame with the horizontal wall row 1 set
    hwall = '0;
    hwall[2*COLS-1 -: COLS] = '1;
    vwall = '0;
    ffff_seen = 0;
    ffff_exp = 0;
    for (int i = 0; i < W * H; i++) begin
      x = i % W;
      y = i / W;
      e = (y >= 15 && y <= 17 && x < 94) ? 16'hFFFF : -1;
      if ((e < 0 ? ref_pix(i, hwall, vwall, m_col, m_row) : 16'(e)) == 16'hFFFF)
        ffff_exp++;
      send_pix(i, e);
    end
    index_valid = 1'b0;
    wait_drain(20);
    chk("frame_wall_count", ffff_seen, ffff_exp);

    // randomized walls, pixels and moves
    for (int r = 0; r < 40; r++) begin
      hwall = HWN'({$urandom(), $urandom()});
      vwall = VWN'($urandom());
      if ($urandom_range(0, 4) == 0) do_restart(1'b0);
      for (int i = 0; i < 8; i++) begin
        send_pix($urandom_range(0, 8191));
        if ($urandom_range(0, 2) == 0) begin
          index_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      index_valid = 1'b0;
      wait_drain(20);
      for (int i = 0; i < 3; i++) do_move($urandom_range(0, 3));
    end

    // open maze: guarantee some successful random moves
    hwall = '0;
    vwall = '0;
    for (int i = 0; i < 20; i++) begin
      do_move($urandom_range(0, 3));
      send_pix($urandom_range(0, 6143));
      index_valid = 1'b0;
      wait_drain(20);
    end

    wait_drain(50);
    chk("final_col", player_col, m_col);
    chk("final_row", player_row, m_row);
    chk("final_won", won, m_won);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
